// File: rtl/bulk_ep_mux.sv
// bulk_ep_mux: steers usb_tlp bulk IN/OUT transfers to NUM_EP endpoint FIFO pairs, IN packets split at MAX_PACKET.
// IN is a zero-latency combinational path; OUT is a one-byte-hold registered stream with no backpressure.
module bulk_ep_mux #(
  parameter int NUM_EP     = 2,
  parameter int EP_BASE    = 1,
  parameter int MAX_PACKET = 512
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            tlp_blk_xfer_endpoint,
  input  logic                  tlp_blk_in_xfer,
  input  logic                  tlp_blk_out_xfer,
  output logic                  tlp_blk_xfer_in_has_data,
  output logic [7:0]            tlp_blk_xfer_in_data,
  output logic                  tlp_blk_xfer_in_data_valid,
  input  logic                  tlp_blk_xfer_in_data_ready,
  output logic                  tlp_blk_xfer_in_data_last,
  output logic                  tlp_blk_xfer_out_ready_read,
  input  logic [7:0]            tlp_blk_xfer_out_data,
  input  logic                  tlp_blk_xfer_out_data_valid,
  output logic [NUM_EP-1:0]     ep_blk_in_xfer,
  input  logic [NUM_EP-1:0]     ep_blk_xfer_in_has_data,
  input  logic [8*NUM_EP-1:0]   ep_blk_xfer_in_data,
  input  logic [NUM_EP-1:0]     ep_blk_xfer_in_data_valid,
  output logic [NUM_EP-1:0]     ep_blk_xfer_in_data_ready,
  input  logic [NUM_EP-1:0]     ep_blk_xfer_in_data_last,
  output logic [NUM_EP-1:0]     ep_blk_out_xfer,
  input  logic [NUM_EP-1:0]     ep_blk_xfer_out_ready_read,
  output logic [7:0]            ep_blk_xfer_out_data,
  output logic [NUM_EP-1:0]     ep_blk_xfer_out_data_valid,
  input  logic [NUM_EP-1:0]     ep_blk_xfer_out_data_ready,
  output logic [NUM_EP-1:0]     ep_blk_xfer_out_data_last,
  output logic [NUM_EP-1:0]     out_overflow_o
);
  localparam int CW = ($clog2(MAX_PACKET) > 8) ? $clog2(MAX_PACKET) : 8;
  localparam int SW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IN     = 3'd1,
    ST_OUT    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_sel;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic [7:0]        r_hold;
  logic              r_hold_v;
  logic [7:0]        r_out_dat;
  logic [NUM_EP-1:0] r_out_vld;
  logic [NUM_EP-1:0] r_out_last;
  logic [NUM_EP-1:0] r_ovf;

  logic [4:0]        w_ep_off;
  logic              w_mapped;
  logic [SW-1:0]     w_sel;
  logic [NUM_EP-1:0] w_sel_oh;
  logic              w_in_act;
  logic              w_in_last;
  logic              w_in_hs;
  logic              w_strobe;
  logic              w_flush;

  // Endpoints below EP_BASE wrap the 5-bit offset past 15, so one compare covers both bounds.
  assign w_ep_off = {1'b0, tlp_blk_xfer_endpoint} - 5'(EP_BASE);
  assign w_mapped = (w_ep_off < 5'(NUM_EP));
  assign w_sel    = w_ep_off[SW-1:0];
  assign w_sel_oh = NUM_EP'(1) << r_sel;

  assign tlp_blk_xfer_in_has_data    = reset_n & w_mapped & ep_blk_xfer_in_has_data[w_sel];
  assign tlp_blk_xfer_out_ready_read = reset_n & w_mapped & ep_blk_xfer_out_ready_read[w_sel];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && (w_state_nxt == ST_IN || w_state_nxt == ST_OUT))
        r_sel <= w_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (tlp_blk_in_xfer)
          w_state_nxt = w_mapped ? ST_IN : ST_IGNORE;
        else if (tlp_blk_out_xfer)
          w_state_nxt = w_mapped ? ST_OUT : ST_IGNORE;
      end
      ST_IN:     if (!tlp_blk_in_xfer) w_state_nxt = ST_IDLE;
      ST_OUT:    if (!tlp_blk_out_xfer) w_state_nxt = ST_FLUSH;
      ST_FLUSH:  w_state_nxt = ST_IDLE;
      ST_IGNORE: if (!tlp_blk_in_xfer && !tlp_blk_out_xfer) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_in_act  = (r_state == ST_IN) && !r_done;
  assign w_in_last = ep_blk_xfer_in_data_last[r_sel] || (r_cnt == CW'(MAX_PACKET - 1));
  assign w_in_hs   = w_in_act && ep_blk_xfer_in_data_valid[r_sel] && tlp_blk_xfer_in_data_ready;

  assign tlp_blk_xfer_in_data       = (r_state == ST_IN) ? ep_blk_xfer_in_data[8*r_sel +: 8] : 8'h00;
  assign tlp_blk_xfer_in_data_valid = w_in_act && ep_blk_xfer_in_data_valid[r_sel];
  assign tlp_blk_xfer_in_data_last  = w_in_act && w_in_last;

  always_comb begin
    ep_blk_in_xfer            = '0;
    ep_blk_out_xfer           = '0;
    ep_blk_xfer_in_data_ready = '0;
    if (r_state == ST_IN)
      ep_blk_in_xfer[r_sel] = 1'b1;
    if (w_in_act)
      ep_blk_xfer_in_data_ready[r_sel] = tlp_blk_xfer_in_data_ready;
    if (r_state == ST_OUT || r_state == ST_FLUSH)
      ep_blk_out_xfer[r_sel] = 1'b1;
  end

  // A forced split leaves the endpoint's tlast unconsumed; the next IN resumes the stream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_in_hs) begin
      if (w_in_last)
        r_done <= 1'b1;
      if (r_cnt != CW'(MAX_PACKET - 1))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_strobe = (r_state == ST_OUT) && tlp_blk_xfer_out_data_valid;
  assign w_flush  = (r_state == ST_FLUSH) && r_hold_v;

  // Each byte is held until the next strobe or the flush so the final one can carry tlast.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold     <= 8'h00;
      r_hold_v   <= 1'b0;
      r_out_dat  <= 8'h00;
      r_out_vld  <= '0;
      r_out_last <= '0;
      r_ovf      <= '0;
    end else begin
      r_out_vld  <= '0;
      r_out_last <= '0;
      r_ovf      <= r_ovf | (r_out_vld & ~ep_blk_xfer_out_data_ready);
      if (w_strobe) begin
        r_hold   <= tlp_blk_xfer_out_data;
        r_hold_v <= 1'b1;
        if (r_hold_v) begin
          r_out_vld <= w_sel_oh;
          r_out_dat <= r_hold;
        end
      end else if (w_flush) begin
        r_out_vld  <= w_sel_oh;
        r_out_last <= w_sel_oh;
        r_out_dat  <= r_hold;
        r_hold_v   <= 1'b0;
      end
    end
  end

  assign ep_blk_xfer_out_data       = r_out_dat;
  assign ep_blk_xfer_out_data_valid = r_out_vld;
  assign ep_blk_xfer_out_data_last  = r_out_last;
  assign out_overflow_o             = r_ovf;

endmodule

// File: tb/tb_bulk_ep_mux.sv
// Bench for bulk_ep_mux: directed IN/OUT transfers, expected bytes queued at issue, popped by a monitor.
module tb_bulk_ep_mux;
  localparam int NUM_EP     = 2;
  localparam int EP_BASE    = 1;
  localparam int MAX_PACKET = 512;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [3:0]          tlp_blk_xfer_endpoint = 4'd0;
  logic                tlp_blk_in_xfer = 1'b0;
  logic                tlp_blk_out_xfer = 1'b0;
  logic                tlp_blk_xfer_in_has_data;
  logic [7:0]          tlp_blk_xfer_in_data;
  logic                tlp_blk_xfer_in_data_valid;
  logic                tlp_blk_xfer_in_data_ready = 1'b0;
  logic                tlp_blk_xfer_in_data_last;
  logic                tlp_blk_xfer_out_ready_read;
  logic [7:0]          tlp_blk_xfer_out_data = 8'h00;
  logic                tlp_blk_xfer_out_data_valid = 1'b0;
  logic [NUM_EP-1:0]   ep_blk_in_xfer;
  logic [NUM_EP-1:0]   ep_blk_xfer_in_has_data = '0;
  logic [8*NUM_EP-1:0] ep_blk_xfer_in_data = '0;
  logic [NUM_EP-1:0]   ep_blk_xfer_in_data_valid = '0;
  logic [NUM_EP-1:0]   ep_blk_xfer_in_data_ready;
  logic [NUM_EP-1:0]   ep_blk_xfer_in_data_last = '0;
  logic [NUM_EP-1:0]   ep_blk_out_xfer;
  logic [NUM_EP-1:0]   ep_blk_xfer_out_ready_read = '0;
  logic [7:0]          ep_blk_xfer_out_data;
  logic [NUM_EP-1:0]   ep_blk_xfer_out_data_valid;
  logic [NUM_EP-1:0]   ep_blk_xfer_out_data_ready = '1;
  logic [NUM_EP-1:0]   ep_blk_xfer_out_data_last;
  logic [NUM_EP-1:0]   out_overflow_o;

  bulk_ep_mux #(.NUM_EP(NUM_EP), .EP_BASE(EP_BASE), .MAX_PACKET(MAX_PACKET)) dut (
    .clock                       (clock),
    .reset_n                     (reset_n),
    .tlp_blk_xfer_endpoint       (tlp_blk_xfer_endpoint),
    .tlp_blk_in_xfer             (tlp_blk_in_xfer),
    .tlp_blk_out_xfer            (tlp_blk_out_xfer),
    .tlp_blk_xfer_in_has_data    (tlp_blk_xfer_in_has_data),
    .tlp_blk_xfer_in_data        (tlp_blk_xfer_in_data),
    .tlp_blk_xfer_in_data_valid  (tlp_blk_xfer_in_data_valid),
    .tlp_blk_xfer_in_data_ready  (tlp_blk_xfer_in_data_ready),
    .tlp_blk_xfer_in_data_last   (tlp_blk_xfer_in_data_last),
    .tlp_blk_xfer_out_ready_read (tlp_blk_xfer_out_ready_read),
    .tlp_blk_xfer_out_data       (tlp_blk_xfer_out_data),
    .tlp_blk_xfer_out_data_valid (tlp_blk_xfer_out_data_valid),
    .ep_blk_in_xfer              (ep_blk_in_xfer),
    .ep_blk_xfer_in_has_data     (ep_blk_xfer_in_has_data),
    .ep_blk_xfer_in_data         (ep_blk_xfer_in_data),
    .ep_blk_xfer_in_data_valid   (ep_blk_xfer_in_data_valid),
    .ep_blk_xfer_in_data_ready   (ep_blk_xfer_in_data_ready),
    .ep_blk_xfer_in_data_last    (ep_blk_xfer_in_data_last),
    .ep_blk_out_xfer             (ep_blk_out_xfer),
    .ep_blk_xfer_out_ready_read  (ep_blk_xfer_out_ready_read),
    .ep_blk_xfer_out_data        (ep_blk_xfer_out_data),
    .ep_blk_xfer_out_data_valid  (ep_blk_xfer_out_data_valid),
    .ep_blk_xfer_out_data_ready  (ep_blk_xfer_out_data_ready),
    .ep_blk_xfer_out_data_last   (ep_blk_xfer_out_data_last),
    .out_overflow_o              (out_overflow_o)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [8:0]          in_q[$];
  logic [NUM_EP+8:0]   out_q[$];
  int                  src_idx[NUM_EP];
  int                  src_len[NUM_EP];
  logic [31:0]         all_out;

  assign all_out = {tlp_blk_xfer_in_has_data, tlp_blk_xfer_in_data, tlp_blk_xfer_in_data_valid,
                    tlp_blk_xfer_in_data_last, tlp_blk_xfer_out_ready_read, ep_blk_in_xfer,
                    ep_blk_xfer_in_data_ready, ep_blk_out_xfer, ep_blk_xfer_out_data,
                    ep_blk_xfer_out_data_valid, ep_blk_xfer_out_data_last, out_overflow_o};

  function automatic logic [7:0] pat(input int c, input int i);
    return 8'(i * 3 + c * 17 + 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int c = 0; c < NUM_EP; c++) begin
      ep_blk_xfer_in_data_valid[c] = (src_idx[c] < src_len[c]);
      ep_blk_xfer_in_has_data[c]   = (src_idx[c] < src_len[c]);
      ep_blk_xfer_in_data_last[c]  = (src_idx[c] == src_len[c] - 1);
      ep_blk_xfer_in_data[8*c +: 8] = pat(c, src_idx[c]);
    end
  endtask

  // Monitor: every TLP-side IN handshake and every endpoint-side OUT valid pops one expectation.
  always @(negedge clock) begin
    if (reset_n && tlp_blk_xfer_in_data_valid && tlp_blk_xfer_in_data_ready) begin
      checks++;
      if (in_q.size() == 0) begin
        errors++;
        $display("FAIL in_byte_unexpected: got %h", {tlp_blk_xfer_in_data, tlp_blk_xfer_in_data_last});
      end else begin
        logic [8:0] e;
        e = in_q.pop_front();
        if ({tlp_blk_xfer_in_data, tlp_blk_xfer_in_data_last} !== e) begin
          errors++;
          $display("FAIL in_byte: got %h expected %h",
                   {tlp_blk_xfer_in_data, tlp_blk_xfer_in_data_last}, e);
        end
      end
    end
    if (reset_n && ep_blk_xfer_out_data_valid != '0) begin
      checks++;
      if (out_q.size() == 0) begin
        errors++;
        $display("FAIL out_byte_unexpected: got %h",
                 {ep_blk_xfer_out_data_valid, ep_blk_xfer_out_data, ep_blk_xfer_out_data_last != '0});
      end else begin
        logic [NUM_EP+8:0] e;
        e = out_q.pop_front();
        if ({ep_blk_xfer_out_data_valid, ep_blk_xfer_out_data, ep_blk_xfer_out_data_last == ep_blk_xfer_out_data_valid} !== e) begin
          errors++;
          $display("FAIL out_byte: got vld=%b dat=%h last=%b expected %h", ep_blk_xfer_out_data_valid,
                   ep_blk_xfer_out_data, ep_blk_xfer_out_data_last, e);
        end
      end
    end
  end

  task automatic do_in(input logic [3:0] ep, input int ch, input int nbytes);
    int  n;
    int  cyc;
    logic hs;
    for (int k = 0; k < nbytes; k++)
      in_q.push_back({pat(ch, src_idx[ch] + k), (k == nbytes - 1)});
    @(posedge clock); #1;
    tlp_blk_xfer_endpoint      = ep;
    tlp_blk_in_xfer            = 1'b1;
    tlp_blk_xfer_in_data_ready = 1'b1;
    @(negedge clock);
    chk("in_first_cycle_valid", 32'(tlp_blk_xfer_in_data_valid), 32'd0);
    chk("in_has_data", 32'(tlp_blk_xfer_in_has_data), 32'(src_idx[ch] < src_len[ch]));
    @(posedge clock); #1;
    @(negedge clock);
    chk("in_xfer_onehot", 32'(ep_blk_in_xfer), 32'(1 << ch));
    n = 0;
    cyc = 0;
    while (n < nbytes && cyc < 3000) begin
      hs = ep_blk_xfer_in_data_ready[ch] && ep_blk_xfer_in_data_valid[ch];
      @(posedge clock); #1;
      if (hs) begin
        src_idx[ch]++;
        n++;
        drive_src();
      end
      cyc++;
      @(negedge clock);
    end
    chk("in_handshake_count", 32'(n), 32'(nbytes));
    chk("in_valid_after_last", 32'(tlp_blk_xfer_in_data_valid), 32'd0);
    chk("in_ep_ready_after_last", 32'(ep_blk_xfer_in_data_ready), 32'd0);
    @(posedge clock); #1;
    tlp_blk_in_xfer = 1'b0;
    @(posedge clock); #1;
    chk("in_xfer_released", 32'(ep_blk_in_xfer), 32'd0);
  endtask

  task automatic do_out(input logic [3:0] ep, input int ch, input int n, input logic [7:0] base);
    logic [NUM_EP-1:0] oh;
    oh = NUM_EP'(1) << ch;
    for (int k = 0; k < n; k++)
      out_q.push_back({oh, 8'(base + 8'(k)), 1'(k == n - 1)});
    @(posedge clock); #1;
    tlp_blk_xfer_endpoint = ep;
    tlp_blk_out_xfer      = 1'b1;
    @(posedge clock); #1;
    chk("out_xfer_onehot", 32'(ep_blk_out_xfer), 32'(oh));
    for (int k = 0; k < n; k++) begin
      tlp_blk_xfer_out_data       = base + 8'(k);
      tlp_blk_xfer_out_data_valid = 1'b1;
      @(posedge clock); #1;
    end
    tlp_blk_xfer_out_data_valid = 1'b0;
    tlp_blk_out_xfer            = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("out_xfer_released", 32'(ep_blk_out_xfer), 32'd0);
  endtask

  initial begin
    for (int c = 0; c < NUM_EP; c++) begin
      src_idx[c] = 0;
      src_len[c] = 0;
    end
    tlp_blk_xfer_endpoint      = 4'd1;
    ep_blk_xfer_in_has_data    = '1;
    ep_blk_xfer_out_ready_read = '1;
    #12;
    chk("reset_outputs_zero", all_out, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Live status mux: {endpoint, has_data in, ready_read in, expected has_data, expected ready_read}
    begin
      logic [3:0] eps [0:4];
      logic [1:0] hd  [0:4];
      logic [1:0] rr  [0:4];
      logic       ehd [0:4];
      logic       err [0:4];
      eps = '{4'd1, 4'd2, 4'd2, 4'd0, 4'd3};
      hd  = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
      rr  = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b11};
      ehd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      err = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
        tlp_blk_xfer_endpoint      = eps[i];
        ep_blk_xfer_in_has_data    = hd[i];
        ep_blk_xfer_out_ready_read = rr[i];
        #1;
        chk("status_has_data", 32'(tlp_blk_xfer_in_has_data), 32'(ehd[i]));
        chk("status_ready_read", 32'(tlp_blk_xfer_out_ready_read), 32'(err[i]));
      end
    end
    ep_blk_xfer_out_ready_read = '1;

    // 10-byte stream with tlast on byte 9 from endpoint 1
    src_len[0] = 10;
    drive_src();
    do_in(4'd1, 0, 10);
    chk("ep1_drained", 32'(src_idx[0]), 32'd10);

    // 600-byte stream from endpoint 2: forced split at 512, then 88 bytes with real tlast
    src_len[1] = 600;
    drive_src();
    do_in(4'd2, 1, 512);
    chk("ep2_split_pos", 32'(src_idx[1]), 32'd512);
    do_in(4'd2, 1, 88);
    chk("ep2_drained", 32'(src_idx[1]), 32'd600);

    // OUT to endpoint 2: A0..A4, last on A4, channel 0 silent
    do_out(4'd2, 1, 5, 8'hA0);
    chk("no_overflow_after_out", 32'(out_overflow_o), 32'd0);

    // Unmapped endpoint 7 with both transfer types and a stray OUT strobe
    src_len[0] = 20;
    drive_src();
    @(posedge clock); #1;
    tlp_blk_xfer_endpoint       = 4'd7;
    tlp_blk_in_xfer             = 1'b1;
    tlp_blk_out_xfer            = 1'b1;
    tlp_blk_xfer_in_data_ready  = 1'b1;
    tlp_blk_xfer_out_data       = 8'h55;
    tlp_blk_xfer_out_data_valid = 1'b1;
    @(negedge clock);
    chk("unmapped_has_data", 32'(tlp_blk_xfer_in_has_data), 32'd0);
    chk("unmapped_ready_read", 32'(tlp_blk_xfer_out_ready_read), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("unmapped_ep_strobes", 32'({ep_blk_in_xfer, ep_blk_out_xfer, ep_blk_xfer_in_data_ready}), 32'd0);
    chk("unmapped_in_valid", 32'(tlp_blk_xfer_in_data_valid), 32'd0);
    @(posedge clock); #1;
    tlp_blk_in_xfer             = 1'b0;
    tlp_blk_out_xfer            = 1'b0;
    tlp_blk_xfer_out_data_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("unmapped_src_untouched", 32'(src_idx[0]), 32'd10);

    // OUT 3 bytes to endpoint 1 with its OUT ready held low: overflow is sticky
    ep_blk_xfer_out_data_ready[0] = 1'b0;
    do_out(4'd1, 0, 3, 8'h30);
    ep_blk_xfer_out_data_ready[0] = 1'b1;
    chk("overflow_set", 32'(out_overflow_o), 32'b01);
    repeat (5) @(posedge clock);
    #1;
    chk("overflow_sticky", 32'(out_overflow_o), 32'b01);

    // Reset mid-IN: endpoint 1 presenting data, TLP not ready
    @(posedge clock); #1;
    tlp_blk_xfer_endpoint      = 4'd1;
    tlp_blk_xfer_in_data_ready = 1'b0;
    tlp_blk_in_xfer            = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    chk("mid_in_valid", 32'(tlp_blk_xfer_in_data_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_in_outputs_zero", all_out, 32'd0);

    chk("in_queue_empty", 32'(in_q.size()), 32'd0);
    chk("out_queue_empty", 32'(out_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
